// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg
// Constants and types shared by the accelerator controller and the result FIFO.
//   FIFO_CMD_*      : encodings of the 2-bit fifo_command bus
//   drain_state_t   : state encoding of the result FIFO drain sequencer
//   is_drain_request: edge detector for the READ command
package conv_acc_pkg;

    localparam logic [1:0] FIFO_CMD_IDLE  = 2'b00;
    localparam logic [1:0] FIFO_CMD_READ  = 2'b01;
    localparam logic [1:0] FIFO_CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMPLETE = 2'd2
    } drain_state_t;

    // A READ counts only on the first cycle it appears. Any other previous
    // command, including the reserved 2'b11, re-arms the detector.
    function automatic logic is_drain_request(input logic [1:0] cmd,
                                              input logic [1:0] cmd_prev);
        return (cmd == FIFO_CMD_READ) && (cmd_prev != FIFO_CMD_READ);
    endfunction

endpackage

// File: rtl/result_ram_sdp.sv
// result_ram_sdp
// Simple dual-port RAM, DEPTH x DATA_WIDTH. Synchronous write, synchronous
// registered read gated by rd_en. The read register holds its value while
// rd_en is low, so it can act directly as an output register.
//   clk, reset        : clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read port request
//   rd_data           : registered read data
module result_ram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The array itself is never cleared; the owner discards contents by
    // resetting its pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read and write to the same address in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_result_fifo.sv
// conv_result_fifo
// Collects one convolution result per WRITE command and, on a READ command,
// drains all stored words to the host over a valid/ready stream, then pulses
// drain_done.
//   clk, reset     : clock, synchronous active-low reset
//   fifo_command   : 00 idle, 01 drain request, 10 write, 11 ignored
//   wr_data        : result word captured on a write
//   out_data/out_valid/out_ready : host stream
//   count/full/empty : words in storage (not counting the output register)
//   overflow       : sticky, a write was dropped because storage was full
//   drain_done     : one-cycle pulse at the end of a drain
//   busy           : a drain is in progress
module conv_result_fifo
    import conv_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            fifo_command,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  drain_done,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    drain_state_t          state;
    drain_state_t          state_next;
    logic [1:0]            cmd_prev;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  out_valid_q;
    logic                  overflow_q;
    logic                  wr_req;
    logic                  wr_en;
    logic                  load;

    // A load refills the output register whenever it is empty or being
    // consumed. Because it looks at the registered count, a word written into
    // an empty FIFO becomes loadable one cycle later. A full FIFO may still
    // accept a write when a load frees a slot in the same cycle.
    always_comb begin
        wr_req = (fifo_command == FIFO_CMD_WRITE);
        load   = (state == ST_DRAIN) && (count_q != '0) && (!out_valid_q || out_ready);
        wr_en  = wr_req && ((count_q != FULL_COUNT) || load);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (is_drain_request(fifo_command, cmd_prev)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!load && (count_q == '0) && (!out_valid_q || out_ready)) begin
                    state_next = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_prev    <= FIFO_CMD_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state    <= state_next;
            cmd_prev <= fifo_command;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (load) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (wr_req && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // The RAM read register doubles as the out_data register.
    result_ram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_en  (load),
        .rd_addr(rd_ptr),
        .rd_data(out_data)
    );

    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign full       = (count_q == FULL_COUNT);
    assign empty      = (count_q == '0);
    assign overflow   = overflow_q;
    assign drain_done = (state == ST_COMPLETE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_conv_result_fifo.sv
// tb_conv_result_fifo
// Directed bench for conv_result_fifo: reset, basic drain, backpressure,
// full/overflow/wrap, READ edge detection, reserved command, reset mid-drain.
module tb_conv_result_fifo;
    import conv_acc_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  fifo_command;
    logic [31:0] wr_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        drain_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bit bpPattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    conv_result_fifo #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_command(fifo_command),
        .wr_data     (wr_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .drain_done  (drain_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, let one active edge pass, then settle 1ns after it.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] data,
                                 input logic rdy);
        fifo_command = cmd;
        wr_data      = data;
        out_ready    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Holds READ until the drain finishes, collecting every handshake. With
    // backpressure the ready pattern advances only on cycles where a word is
    // offered, so the stalls land on real data.
    task automatic runDrain(input string tag, input int expWords,
                            input logic [31:0] firstWord, input bit useBp);
        logic [31:0] got [$];
        int          doneCount = 0;
        int          bpIdx     = 0;
        bit          finished  = 0;
        bit          stalled;
        logic [31:0] heldData;
        logic [8:0]  heldCount;
        logic        rdy;
        for (int c = 0; c < 600 && !finished; c++) begin
            rdy = 1'b1;
            if (useBp && out_valid && bpIdx < 7) begin
                rdy = bpPattern[bpIdx];
                bpIdx++;
            end
            if (out_valid && rdy) got.push_back(out_data);
            stalled   = out_valid && !rdy;
            heldData  = out_data;
            heldCount = count;
            applyStimulus(FIFO_CMD_READ, 32'h0, rdy);
            if (stalled) begin
                checkOutput({tag, " stall valid"}, out_valid, 1);
                checkOutput({tag, " stall data"}, out_data, heldData);
                checkOutput({tag, " stall count"}, count, heldCount);
            end
            if (drain_done) doneCount++;
            if (doneCount > 0 && !busy) finished = 1;
        end
        checkOutput({tag, " finished"}, finished, 1);
        checkOutput({tag, " words"}, got.size(), expWords);
        for (int i = 0; i < got.size() && i < expWords; i++) begin
            checkOutput($sformatf("%s word%0d", tag, i), got[i], firstWord + 32'(i));
        end
        checkOutput({tag, " done pulses"}, doneCount, 1);
        checkOutput({tag, " count"}, count, 0);
        checkOutput({tag, " valid idle"}, out_valid, 0);
        checkOutput({tag, " done low"}, drain_done, 0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;
        int validSeen;
        reset = 1'b0;
        fifo_command = FIFO_CMD_IDLE;
        wr_data = '0;
        out_ready = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) applyStimulus(FIFO_CMD_IDLE, 32'h0, 0);
        checkOutput("reset valid", out_valid, 0);
        checkOutput("reset data", out_data, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset empty", empty, 1);
        checkOutput("reset full", full, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", drain_done, 0);
        reset = 1'b1;
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 0);

        // Basic drain with exact timing
        for (int i = 0; i < 4; i++) begin
            applyStimulus(FIFO_CMD_WRITE, 32'hA0 + 32'(i), 1);
            applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        end
        checkOutput("basic count", count, 4);
        checkOutput("basic empty", empty, 0);
        checkOutput("basic idle valid", out_valid, 0);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("basic k busy", busy, 1);
        checkOutput("basic k valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(FIFO_CMD_READ, 32'h0, 1);
            checkOutput($sformatf("basic valid%0d", i), out_valid, 1);
            checkOutput($sformatf("basic data%0d", i), out_data, 32'hA0 + 32'(i));
        end
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("basic done", drain_done, 1);
        checkOutput("basic done valid", out_valid, 0);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("basic done end", drain_done, 0);
        checkOutput("basic idle", busy, 0);
        checkOutput("basic count0", count, 0);

        // Backpressure
        for (int i = 0; i < 4; i++) applyStimulus(FIFO_CMD_WRITE, 32'hA0 + 32'(i), 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        runDrain("bp", 4, 32'hA0, 1);

        // Empty drain and READ edge detection
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        checkOutput("empty pre", empty, 1);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("empty k busy", busy, 1);
        checkOutput("empty k done", drain_done, 0);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("empty k1 done", drain_done, 1);
        checkOutput("empty k1 valid", out_valid, 0);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("empty k2 done", drain_done, 0);
        checkOutput("empty k2 busy", busy, 0);
        pulses = 0;
        validSeen = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(FIFO_CMD_READ, 32'h0, 1);
            if (drain_done || busy) pulses++;
            if (out_valid) validSeen++;
        end
        checkOutput("held read retrigger", pulses, 0);
        checkOutput("held read valid", validSeen, 0);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("rearm busy", busy, 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        checkOutput("rearm done", drain_done, 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        applyStimulus(2'b11, 32'h0, 1);
        checkOutput("cmd11 busy", busy, 0);
        checkOutput("cmd11 count", count, 0);
        applyStimulus(2'b11, 32'h0, 1);
        checkOutput("cmd11 done", drain_done, 0);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("read after 11 busy", busy, 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        checkOutput("read after 11 done", drain_done, 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);

        // Full, overflow, wrap
        for (int i = 0; i < 256; i++) applyStimulus(FIFO_CMD_WRITE, 32'(i), 1);
        checkOutput("full flag", full, 1);
        checkOutput("full count", count, 256);
        checkOutput("full no overflow", overflow, 0);
        applyStimulus(FIFO_CMD_WRITE, 32'hDEAD, 1);
        checkOutput("drop count", count, 256);
        checkOutput("drop overflow", overflow, 1);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        runDrain("full", 256, 32'h0, 0);
        checkOutput("overflow sticky", overflow, 1);
        checkOutput("empty after full", empty, 1);
        for (int i = 0; i < 10; i++) applyStimulus(FIFO_CMD_WRITE, 32'h300 + 32'(i), 1);
        checkOutput("wrap count", count, 10);
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        runDrain("wrap", 10, 32'h300, 0);

        // Reset mid-drain
        for (int i = 0; i < 8; i++) applyStimulus(FIFO_CMD_WRITE, 32'h50 + 32'(i), 1);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("mid word0", out_data, 32'h50);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("mid word1", out_data, 32'h51);
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("mid word2", out_data, 32'h52);
        reset = 1'b0;
        applyStimulus(FIFO_CMD_READ, 32'h0, 1);
        checkOutput("mid rst valid", out_valid, 0);
        checkOutput("mid rst busy", busy, 0);
        checkOutput("mid rst count", count, 0);
        checkOutput("mid rst empty", empty, 1);
        checkOutput("mid rst overflow", overflow, 0);
        checkOutput("mid rst done", drain_done, 0);
        reset = 1'b1;
        applyStimulus(FIFO_CMD_IDLE, 32'h0, 1);
        checkOutput("mid post done", drain_done, 0);
        checkOutput("mid post busy", busy, 0);
        runDrain("post-reset", 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
